// File: rtl/project_pkg.sv
// Project-wide types for the data store: word width, default depth, memory FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package project_pkg;

  localparam int word_size = 32;
  localparam int mem_size  = 16;

  typedef logic [word_size-1:0] word_t;

  // Only used when the clear-on-reset sequencer is built in.
  typedef enum logic {MS_CLEAR, MS_RUN} mem_state_t;

endpackage

// File: rtl/mem_dp_rd_pipe.sv
// Read-return pipeline: delays a read word and its valid strobe by READ_LAT (1 or 2) cycles.
// Latency: READ_LAT edges from in_vld to out_vld; out_dat holds its last value while out_vld=0.
// Backpressure: none; accepts one word per cycle, unconditionally.
//
// Ports: clk, rst (async, active-high; clears all stages), in_vld/in_dat (word captured this
// edge), out_vld/out_dat (delayed word and one-cycle valid pulse).
module rd_pipe #(
  parameter int WIDTH    = 32,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat
);

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_dat_q, s1_dat_d;

  // Data only loads on a valid word so the output holds between pulses.
  always_comb begin
    s1_vld_d = in_vld;
    s1_dat_d = in_vld ? in_dat : s1_dat_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic             s2_vld_q, s2_vld_d;
      logic [WIDTH-1:0] s2_dat_q, s2_dat_d;

      always_comb begin
        s2_vld_d = s1_vld_q;
        s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_vld_q <= 1'b0;
          s2_dat_q <= '0;
        end else begin
          s2_vld_q <= s2_vld_d;
          s2_dat_q <= s2_dat_d;
        end
      end

      assign out_vld = s2_vld_q;
      assign out_dat = s2_dat_q;
    end else begin : g_lat1
      assign out_vld = s1_vld_q;
      assign out_dat = s1_dat_q;
    end
  endgenerate

endmodule

// File: rtl/mem_dp.sv
// Dual-port data memory: port A read/write with byte enables (write-first), port B read-only.
// Latency: READ_LAT (1 or 2) cycles from acceptance to a_valid/b_valid; one request/cycle/port.
// Backpressure: requests are accepted only while ready=1; anything presented while ready=0 is dropped.
//
// Ports: clk, rst (async, active-high); A: a_en, a_we, a_be, a_addr, a_wd -> a_rd, a_valid;
// B: b_en, b_addr -> b_rd, b_valid; ready (memory accepting requests).
// Build option MEM_DP_CLEAR_EN: zero the whole array after reset before raising ready.
module mem_dp
  import project_pkg::*;
#(
  parameter int WIDTH    = word_size,
  parameter int DEPTH    = mem_size,
  parameter int READ_LAT = 1,
  parameter int B_BYPASS = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NB      = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_en,
  input  logic             a_we,
  input  logic [NB-1:0]    a_be,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wd,
  output logic [WIDTH-1:0] a_rd,
  output logic             a_valid,
  input  logic             b_en,
  input  logic [AW-1:0]    b_addr,
  output logic [WIDTH-1:0] b_rd,
  output logic             b_valid,
  output logic             ready
);

  logic [WIDTH-1:0] mem_array [DEPTH];

  logic             ready_q;
  logic             a_acc, b_acc, a_in_rng, b_in_rng, collide;
  logic [WIDTH-1:0] a_old, a_merged, a_rd_dat, b_old, b_rd_dat;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_dat;
  logic [NB-1:0]    wr_be;

  assign ready = ready_q;
  assign a_acc = ready_q & a_en;
  assign b_acc = ready_q & b_en;

  // Read side: A returns the post-write word; out-of-range addresses read as zero.
  always_comb begin
    a_in_rng = int'(a_addr) < DEPTH;
    b_in_rng = int'(b_addr) < DEPTH;
    a_old    = a_in_rng ? mem_array[a_addr] : '0;
    b_old    = b_in_rng ? mem_array[b_addr] : '0;
    a_merged = a_old;
    if (a_we) begin
      for (int i = 0; i < NB; i++) begin
        if (a_be[i]) a_merged[8*i +: 8] = a_wd[8*i +: 8];
      end
    end
    a_rd_dat = a_in_rng ? a_merged : '0;
    collide  = a_acc & a_we & a_in_rng & (a_addr == b_addr);
    b_rd_dat = (collide && (B_BYPASS != 0)) ? a_merged : b_old;
  end

`ifdef MEM_DP_CLEAR_EN
  mem_state_t    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ready_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    if (state_q == MS_CLEAR) begin
      if (ptr_q == AW'(DEPTH - 1)) begin
        state_d = MS_RUN;
        ready_d = 1'b1;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MS_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end
`endif

  // Single write port shared by port A and the clear sequencer (A is never ready while clearing).
  always_comb begin
    wr_en   = a_acc & a_we & a_in_rng;
    wr_addr = a_addr;
    wr_dat  = a_wd;
    wr_be   = a_be;
`ifdef MEM_DP_CLEAR_EN
    if (state_q == MS_CLEAR) begin
      wr_en   = ~rst;
      wr_addr = ptr_q;
      wr_dat  = '0;
      wr_be   = '1;
    end
`endif
  end

  // No reset on the array: contents survive rst and the block maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem_array[wr_addr][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

  rd_pipe #(.WIDTH(WIDTH), .READ_LAT(READ_LAT)) u_a_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (a_acc),
    .in_dat  (a_rd_dat),
    .out_vld (a_valid),
    .out_dat (a_rd)
  );

  rd_pipe #(.WIDTH(WIDTH), .READ_LAT(READ_LAT)) u_b_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (b_acc),
    .in_dat  (b_rd_dat),
    .out_vld (b_valid),
    .out_dat (b_rd)
  );

endmodule

// File: tb/tb_mem_dp.sv
// Testbench for mem_dp: two instances (READ_LAT=1/B_BYPASS=1 and READ_LAT=2/B_BYPASS=0) share stimulus.
// Expected words are pushed to per-port scoreboard queues with their due cycle and checked on negedge.
// Works with or without MEM_DP_CLEAR_EN defined.
module tb_mem_dp;

  localparam int W  = 32;
  localparam int D  = 12;
  localparam int AW = 4;
  localparam int NB = 4;
`ifdef MEM_DP_CLEAR_EN
  localparam int EXP_RDY = D;
`else
  localparam int EXP_RDY = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_en = 1'b0, a_we = 1'b0, b_en = 1'b0;
  logic [NB-1:0] a_be = '0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [W-1:0]  a_wd = '0;

  logic [W-1:0]  a_rd1, b_rd1, a_rd2, b_rd2;
  logic          a_valid1, b_valid1, ready1, a_valid2, b_valid2, ready2;

  always #5 clk = ~clk;

  mem_dp #(.WIDTH(W), .DEPTH(D), .READ_LAT(1), .B_BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wd(a_wd), .a_rd(a_rd1), .a_valid(a_valid1), .b_en(b_en), .b_addr(b_addr),
    .b_rd(b_rd1), .b_valid(b_valid1), .ready(ready1)
  );

  mem_dp #(.WIDTH(W), .DEPTH(D), .READ_LAT(2), .B_BYPASS(0)) dut2 (
    .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
    .a_wd(a_wd), .a_rd(a_rd2), .a_valid(a_valid2), .b_en(b_en), .b_addr(b_addr),
    .b_rd(b_rd2), .b_valid(b_valid2), .ready(ready2)
  );

  typedef struct {
    logic [W-1:0] dat;
    int           due;
  } exp_t;

  // Streams: 0 = dut1 A, 1 = dut1 B, 2 = dut2 A, 3 = dut2 B.
  exp_t         sbq [4][$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [W-1:0] model [D];
  bit           model_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stream(input int s, input logic vld, input logic [W-1:0] dat);
    bit   exp_v;
    exp_t e;
    exp_v = (sbq[s].size() > 0) && (sbq[s][0].due == cyc);
    if (exp_v || (vld === 1'b1)) begin
      checks++;
      assert (vld === exp_v) else begin
        failures++;
        $error("FAIL valid_stream%0d cyc=%0d observed=%b expected=%b", s, cyc, vld, exp_v);
      end
      if (exp_v) begin
        e = sbq[s].pop_front();
        checks++;
        assert (dat === e.dat) else begin
          failures++;
          $error("FAIL rd_stream%0d cyc=%0d observed=%h expected=%h", s, cyc, dat, e.dat);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk_stream(0, a_valid1, a_rd1);
      chk_stream(1, b_valid1, b_rd1);
      chk_stream(2, a_valid2, a_rd2);
      chk_stream(3, b_valid2, b_rd2);
    end
  end

  task automatic push(input int s, input logic [W-1:0] dat, input int due);
    exp_t e;
    e.dat = dat;
    e.due = due;
    sbq[s].push_back(e);
  endtask

  // One request cycle on both ports; expectations are formed from the model before the edge.
  task automatic step(input bit ae, input bit we, input logic [NB-1:0] be, input logic [AW-1:0] aa,
                      input logic [W-1:0] wd, input bit bn, input logic [AW-1:0] ba);
    logic [W-1:0] old_a, merged, a_exp, b_old, b_exp1;
    bit           a_in, b_in, col;
    a_en = ae; a_we = we; a_be = be; a_addr = aa; a_wd = wd; b_en = bn; b_addr = ba;
    a_in   = int'(aa) < D;
    b_in   = int'(ba) < D;
    old_a  = a_in ? model[aa] : '0;
    merged = old_a;
    if (we) begin
      for (int i = 0; i < NB; i++) if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
    end
    a_exp  = a_in ? merged : '0;
    b_old  = b_in ? model[ba] : '0;
    col    = ae && we && a_in && (aa == ba);
    b_exp1 = col ? merged : b_old;
    @(posedge clk); #1;
    if (model_ready) begin
      if (ae) begin
        push(0, a_exp, cyc);
        push(2, a_exp, cyc + 1);
        if (we && a_in) model[aa] = merged;
      end
      if (bn) begin
        push(1, b_exp1, cyc);
        push(3, b_old, cyc + 1);
      end
    end
  endtask

  task automatic idle(input int n);
    a_en = 1'b0; a_we = 1'b0; b_en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input bit try_drop);
    int n;
    rst = 1'b1;
    model_ready = 1'b0;
    for (int s = 0; s < 4; s++) sbq[s].delete();
`ifdef MEM_DP_CLEAR_EN
    for (int i = 0; i < D; i++) model[i] = '0;
`endif
    a_en = 1'b0; a_we = 1'b0; b_en = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_ready1", {31'b0, ready1}, 32'd0);
    chk("rst_ready2", {31'b0, ready2}, 32'd0);
    chk("rst_a_valid1", {31'b0, a_valid1}, 32'd0);
    chk("rst_b_valid2", {31'b0, b_valid2}, 32'd0);
    chk("rst_a_rd1", a_rd1, 32'd0);
    chk("rst_b_rd2", b_rd2, 32'd0);
    if (try_drop) begin
      a_en = 1'b1; a_we = 1'b1; a_be = '1; a_addr = 4'd2; a_wd = 32'hDEAD; b_en = 1'b1; b_addr = 4'd2;
    end
    rst = 1'b0;
    n = 0;
    while (ready1 !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      a_en = 1'b0; b_en = 1'b0;
    end
    chk("ready_rise_edge", 32'(n), 32'(EXP_RDY));
    chk("ready2_up", {31'b0, ready2}, 32'd1);
    model_ready = 1'b1;
  endtask

  initial begin
    // Reset, ready timing, and a request presented while not ready (must be dropped).
    do_reset(1'b1);

`ifdef MEM_DP_CLEAR_EN
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, '0, 4'(i), '0, 1'b1, 4'(i));
    idle(3);
`endif

    // Fill i*3 then back-to-back B readback.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, '1, 4'(i), 32'(i * 3), 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'(i));
    idle(3);

    // Byte enables, then an all-zero-enable write (no-op) and an A read.
    step(1'b1, 1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, '0);
    step(1'b1, 1'b1, 4'b0101, 4'd5, 32'h11223344, 1'b0, '0);
    step(1'b1, 1'b0, 4'h0, 4'd5, '0, 1'b0, '0);
    step(1'b1, 1'b1, 4'h0, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5);
    idle(3);

    // Collision: B sees new word on dut1, old word on dut2.
    step(1'b1, 1'b1, 4'hF, 4'd7, 32'd1, 1'b0, '0);
    step(1'b1, 1'b1, 4'hF, 4'd7, 32'd2, 1'b1, 4'd7);
    step(1'b1, 1'b0, 4'h0, 4'd7, '0, 1'b1, 4'd7);
    idle(3);

    // Out of range: write to 13 ignored, reads return zero, mem[1] untouched.
    step(1'b1, 1'b1, 4'hF, 4'd1, 32'h55, 1'b0, '0);
    step(1'b1, 1'b1, 4'hF, 4'd13, 32'd9, 1'b0, '0);
    step(1'b1, 1'b0, 4'h0, 4'd13, '0, 1'b1, 4'd13);
    step(1'b1, 1'b0, 4'h0, 4'd0, '0, 1'b1, 4'd1);
    idle(4);
    for (int s = 0; s < 4; s++) chk("queue_drained", 32'(sbq[s].size()), 32'd0);

    // Reset one cycle after a B read: the latency-2 return never appears.
    step(1'b1, 1'b1, 4'hF, 4'd4, 32'h77, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd3);
    a_en = 1'b0; b_en = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    for (int s = 0; s < 4; s++) sbq[s].delete();
    model_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("midrst_b_valid2", {31'b0, b_valid2}, 32'd0);
      chk("midrst_ready", {31'b0, ready2}, 32'd0);
    end
    chk("midrst_b_rd2", b_rd2, 32'd0);
    do_reset(1'b0);

    // Recovery: the write clocked before reset stays (or is cleared when clearing is built in).
    step(1'b1, 1'b0, '0, 4'd4, '0, 1'b1, 4'd3);
    step(1'b1, 1'b1, 4'hF, 4'd8, 32'hCAFE0001, 1'b1, 4'd4);
    step(1'b1, 1'b0, '0, 4'd8, '0, 1'b1, 4'd8);
    idle(4);
    for (int s = 0; s < 4; s++) chk("final_drained", 32'(sbq[s].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
